// File: rtl/ucie_fdi_tx_vc_scheduler_if.sv
// Purpose : bundles the per-VC request queues, the FDI transmit flit bus and the
//           credit side-band seen by ucie_fdi_tx_vc_scheduler.
// Ports   : master = scheduler view (drives vc_req_ready, pl_flit_*, credit status);
//           slave = environment view (drives requests, lp_flit_ready, credit returns).
//           Cancel signals exist only when UCIE_FDI_TX_CANCEL_EN is defined.
interface ucie_fdi_tx_vc_scheduler_if #(
  parameter int FLIT_WIDTH   = 256,
  parameter int NUM_VCS      = 8,
  parameter int CREDIT_WIDTH = 6
);
  logic                            link_up;
  logic [NUM_VCS-1:0]              vc_req_valid;
  logic [NUM_VCS*FLIT_WIDTH-1:0]   vc_req_data;
  logic [NUM_VCS-1:0]              vc_req_sop;
  logic [NUM_VCS-1:0]              vc_req_eop;
  logic [NUM_VCS-1:0]              vc_req_ready;
  logic                            pl_flit_valid;
  logic [FLIT_WIDTH-1:0]           pl_flit_data;
  logic                            pl_flit_sop;
  logic                            pl_flit_eop;
  logic [3:0]                      pl_flit_be;
  logic                            lp_flit_ready;
  logic [NUM_VCS-1:0]              pl_credit_return;
  logic [NUM_VCS*CREDIT_WIDTH-1:0] credit_count;
  logic                            credit_overflow;
`ifdef UCIE_FDI_TX_CANCEL_EN
  logic                            pl_flit_cancel;
  logic                            pl_flit_cancel_ack;

  modport master (
    input  link_up, vc_req_valid, vc_req_data, vc_req_sop, vc_req_eop,
           lp_flit_ready, pl_credit_return, pl_flit_cancel,
    output vc_req_ready, pl_flit_valid, pl_flit_data, pl_flit_sop, pl_flit_eop,
           pl_flit_be, credit_count, credit_overflow, pl_flit_cancel_ack
  );
  modport slave (
    output link_up, vc_req_valid, vc_req_data, vc_req_sop, vc_req_eop,
           lp_flit_ready, pl_credit_return, pl_flit_cancel,
    input  vc_req_ready, pl_flit_valid, pl_flit_data, pl_flit_sop, pl_flit_eop,
           pl_flit_be, credit_count, credit_overflow, pl_flit_cancel_ack
  );
`else
  modport master (
    input  link_up, vc_req_valid, vc_req_data, vc_req_sop, vc_req_eop,
           lp_flit_ready, pl_credit_return,
    output vc_req_ready, pl_flit_valid, pl_flit_data, pl_flit_sop, pl_flit_eop,
           pl_flit_be, credit_count, credit_overflow
  );
  modport slave (
    output link_up, vc_req_valid, vc_req_data, vc_req_sop, vc_req_eop,
           lp_flit_ready, pl_credit_return,
    input  vc_req_ready, pl_flit_valid, pl_flit_data, pl_flit_sop, pl_flit_eop,
           pl_flit_be, credit_count, credit_overflow
  );
`endif
endinterface

// File: rtl/ucie_fdi_tx_vc_scheduler.sv
// Purpose : credit-gated round-robin VC scheduler feeding the FDI transmit flit bus,
//           with packet locking and (UCIE_FDI_TX_CANCEL_EN) last-flit replay on cancel.
// Ports   : clk, reset (async, active-high); fdi = ucie_fdi_tx_vc_scheduler_if.master
//           carrying per-VC requests, FDI flit bus, credit returns and credit status.
// Latency : request accepted in cycle N appears on pl_flit_* in cycle N+1.
// Backpr. : one-entry output register; new grants only when it is empty or draining.
module ucie_fdi_tx_vc_scheduler #(
  parameter int FLIT_WIDTH   = 256,
  parameter int NUM_VCS      = 8,
  parameter int CREDIT_WIDTH = 6,
  parameter int INIT_CREDITS = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  ucie_fdi_tx_vc_scheduler_if.master     fdi
);

  localparam int VCW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam logic [VCW:0]            NVC       = (VCW+1)'(NUM_VCS);
  localparam logic [VCW-1:0]          LAST_VC   = VCW'(NUM_VCS - 1);
  localparam logic [CREDIT_WIDTH-1:0] CRED_MAX  = '1;
  localparam logic [CREDIT_WIDTH-1:0] CRED_INIT = CREDIT_WIDTH'(INIT_CREDITS);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e                  state_q, state_d;
  logic [VCW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [VCW-1:0]          lock_vc_q, lock_vc_d;
  logic [CREDIT_WIDTH-1:0] credit_q [NUM_VCS];
  logic [CREDIT_WIDTH-1:0] credit_d [NUM_VCS];
  logic                    overflow_q, overflow_d;
  logic                    out_vld_q, out_vld_d;
  logic [FLIT_WIDTH-1:0]   out_dat_q, out_dat_d;
  logic                    out_sop_q, out_sop_d;
  logic                    out_eop_q, out_eop_d;

  logic                    load_ok;
  logic                    cancel_blk;
  logic                    reload;
  logic [NUM_VCS-1:0]      eligible;
  logic [NUM_VCS-1:0]      grant;
  logic [VCW-1:0]          grant_idx;
  logic                    grant_any;
  logic [FLIT_WIDTH-1:0]   sel_dat;
  logic                    sel_sop;
  logic                    sel_eop;

  // The output slot can take a new flit when empty or when its flit leaves this cycle.
  assign load_ok = !out_vld_q || fdi.lp_flit_ready;

`ifdef UCIE_FDI_TX_CANCEL_EN
  logic                  rep_vld_q;
  logic [FLIT_WIDTH-1:0] rep_dat_q;
  logic                  rep_sop_q;
  logic                  rep_eop_q;

  // Replay slot tracks the last flit the FDI took; forgotten while the link is down.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_vld_q <= 1'b0;
      rep_dat_q <= '0;
      rep_sop_q <= 1'b0;
      rep_eop_q <= 1'b0;
    end else if (!fdi.link_up) begin
      rep_vld_q <= 1'b0;
    end else if (out_vld_q && fdi.lp_flit_ready) begin
      rep_vld_q <= 1'b1;
      rep_dat_q <= out_dat_q;
      rep_sop_q <= out_sop_q;
      rep_eop_q <= out_eop_q;
    end
  end

  assign cancel_blk             = fdi.pl_flit_cancel && rep_vld_q && fdi.link_up;
  assign reload                 = cancel_blk && load_ok;
  assign fdi.pl_flit_cancel_ack = reload;
`else
  assign cancel_blk = 1'b0;
  assign reload     = 1'b0;
`endif

  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      eligible[v] = fdi.vc_req_valid[v] && (credit_q[v] != '0) &&
                    fdi.link_up && load_ok && !cancel_blk;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state. A link drop abandons any packet in progress.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_any && sel_sop && !sel_eop) state_d = ST_LOCKED;
      ST_LOCKED: if (grant_any && sel_eop)             state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (!fdi.link_up) state_d = ST_IDLE;
  end

  // FSM: outputs (grant). LOCKED grants only the owning VC, even if it cannot send.
  always_comb begin
    logic [VCW:0] cand;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    if (state_q == ST_LOCKED) begin
      if (eligible[lock_vc_q]) begin
        grant[lock_vc_q] = 1'b1;
        grant_idx        = lock_vc_q;
        grant_any        = 1'b1;
      end
    end else begin
      for (int k = 0; k < NUM_VCS; k++) begin
        cand = {1'b0, rr_ptr_q} + (VCW+1)'(k);
        if (cand >= NVC) cand = cand - NVC;
        if (!grant_any && eligible[cand[VCW-1:0]]) begin
          grant[cand[VCW-1:0]] = 1'b1;
          grant_idx            = cand[VCW-1:0];
          grant_any            = 1'b1;
        end
      end
    end
  end

  // Flit mux driven by the one-hot grant.
  always_comb begin
    sel_dat = '0;
    sel_sop = 1'b0;
    sel_eop = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (grant[v]) begin
        sel_dat = fdi.vc_req_data[v*FLIT_WIDTH +: FLIT_WIDTH];
        sel_sop = fdi.vc_req_sop[v];
        sel_eop = fdi.vc_req_eop[v];
      end
    end
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_vc_d = lock_vc_q;
    if (grant_any) begin
      rr_ptr_d = (grant_idx == LAST_VC) ? '0 : grant_idx + 1'b1;
      if (state_q == ST_IDLE) lock_vc_d = grant_idx;
    end
  end

  // Replayed flits bypass the credit and arbitration state entirely.
  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    out_sop_d = out_sop_q;
    out_eop_d = out_eop_q;
    if (load_ok) begin
      out_vld_d = 1'b0;
`ifdef UCIE_FDI_TX_CANCEL_EN
      if (reload) begin
        out_vld_d = 1'b1;
        out_dat_d = rep_dat_q;
        out_sop_d = rep_sop_q;
        out_eop_d = rep_eop_q;
      end else
`endif
      if (grant_any) begin
        out_vld_d = 1'b1;
        out_dat_d = sel_dat;
        out_sop_d = sel_sop;
        out_eop_d = sel_eop;
      end
    end
  end

  // Credits: a return at a saturated counter is lost and flagged.
  always_comb begin
    overflow_d = overflow_q;
    for (int v = 0; v < NUM_VCS; v++) begin
      credit_d[v] = credit_q[v];
      if (!fdi.link_up) begin
        credit_d[v] = CRED_INIT;
      end else if (grant[v] && !fdi.pl_credit_return[v]) begin
        credit_d[v] = credit_q[v] - 1'b1;
      end else if (!grant[v] && fdi.pl_credit_return[v]) begin
        if (credit_q[v] == CRED_MAX) overflow_d = 1'b1;
        else                         credit_d[v] = credit_q[v] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      lock_vc_q  <= '0;
      overflow_q <= 1'b0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
      for (int v = 0; v < NUM_VCS; v++) credit_q[v] <= CRED_INIT;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_vc_q  <= lock_vc_d;
      overflow_q <= overflow_d;
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      out_sop_q  <= out_sop_d;
      out_eop_q  <= out_eop_d;
      for (int v = 0; v < NUM_VCS; v++) credit_q[v] <= credit_d[v];
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      fdi.credit_count[v*CREDIT_WIDTH +: CREDIT_WIDTH] = credit_q[v];
    end
  end

  assign fdi.vc_req_ready    = grant;
  assign fdi.pl_flit_valid   = out_vld_q;
  assign fdi.pl_flit_data    = out_dat_q;
  assign fdi.pl_flit_sop     = out_sop_q;
  assign fdi.pl_flit_eop     = out_eop_q;
  assign fdi.pl_flit_be      = out_vld_q ? 4'hF : 4'h0;
  assign fdi.credit_overflow = overflow_q;

endmodule

// File: tb/tb_ucie_fdi_tx_vc_scheduler.sv
// Purpose : directed self-checking bench for ucie_fdi_tx_vc_scheduler (default build;
//           the cancel/replay scenario is included when UCIE_FDI_TX_CANCEL_EN is defined).
// Ports   : none; instantiates the scheduler interface and the DUT.
module tb_ucie_fdi_tx_vc_scheduler;
  localparam int FW = 256;
  localparam int NV = 8;
  localparam int CW = 6;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  ucie_fdi_tx_vc_scheduler_if #(.FLIT_WIDTH(FW), .NUM_VCS(NV), .CREDIT_WIDTH(CW)) fdi_if ();

  ucie_fdi_tx_vc_scheduler #(
    .FLIT_WIDTH(FW), .NUM_VCS(NV), .CREDIT_WIDTH(CW), .INIT_CREDITS(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fdi   (fdi_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] tag(input int vc, input int seq);
    return {8'(vc), 232'd0, 16'(seq)};
  endfunction

  task automatic set_req(input int vc, input logic vld, input logic sop, input logic eop,
                         input logic [255:0] d);
    fdi_if.vc_req_valid[vc]           = vld;
    fdi_if.vc_req_sop[vc]             = sop;
    fdi_if.vc_req_eop[vc]             = eop;
    fdi_if.vc_req_data[vc*FW +: FW]   = d;
  endtask

  function automatic logic [CW-1:0] cred(input int vc);
    return fdi_if.credit_count[vc*CW +: CW];
  endfunction

  initial begin
    int sent;
    int got;
    int order [3];
    logic [255:0] a5;
    n_chk  = 0;
    n_fail = 0;
    order  = '{1, 3, 5};
    a5     = {32{8'hA5}};
    reset  = 1'b1;
    fdi_if.link_up          = 1'b1;
    fdi_if.vc_req_valid     = '0;
    fdi_if.vc_req_data      = '0;
    fdi_if.vc_req_sop       = '0;
    fdi_if.vc_req_eop       = '0;
    fdi_if.lp_flit_ready    = 1'b1;
    fdi_if.pl_credit_return = '0;
`ifdef UCIE_FDI_TX_CANCEL_EN
    fdi_if.pl_flit_cancel   = 1'b0;
`endif
    #12;
    chk("rst_valid", fdi_if.pl_flit_valid, 0);
    chk("rst_be", fdi_if.pl_flit_be, 0);
    chk("rst_credits", fdi_if.credit_count, {NV{6'd16}});
    chk("rst_ovf", fdi_if.credit_overflow, 0);
    chk("rst_ready", fdi_if.vc_req_ready, 0);
    step();
    reset = 1'b0;

    // VC0 streams single-flit packets until its 16 credits run out.
    for (int c = 0; c <= 16; c++) begin
      set_req(0, 1'b1, 1'b1, 1'b1, tag(0, c));
      #1;
      chk("t1_ready", fdi_if.vc_req_ready, (c < 16) ? 8'h01 : 8'h00);
      if (c == 16) chk("t1_cred0", cred(0), 0);
      step();
      if (c < 16) begin
        chk("t1_valid", fdi_if.pl_flit_valid, 1);
        chk("t1_data", fdi_if.pl_flit_data, tag(0, c));
        chk("t1_be", fdi_if.pl_flit_be, 4'hF);
      end else begin
        chk("t1_empty", fdi_if.pl_flit_valid, 0);
      end
    end
    sent = 16;
    got  = 0;
    for (int c = 0; c < 10; c++) begin
      fdi_if.pl_credit_return[0] = (c < 4);
      set_req(0, 1'b1, 1'b1, 1'b1, tag(0, sent));
      #1;
      if (fdi_if.vc_req_ready[0]) sent++;
      step();
      if (fdi_if.pl_flit_valid) got++;
    end
    fdi_if.pl_credit_return = '0;
    set_req(0, 1'b0, 1'b0, 1'b0, '0);
    chk("t1_extra_flits", got, 4);
    chk("t1_total", sent, 20);
    chk("t1_cred0_end", cred(0), 0);

    // VC1/3/5 contend; rr_ptr is 1 after VC0.
    for (int v = 1; v < 6; v += 2) set_req(v, 1'b1, 1'b1, 1'b1, tag(v, 0));
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t2_ready", fdi_if.vc_req_ready, 8'(1 << order[i % 3]));
      step();
      chk("t2_data", fdi_if.pl_flit_data, tag(order[i % 3], 0));
    end
    for (int v = 1; v < 6; v += 2) set_req(v, 1'b0, 1'b0, 1'b0, '0);
    chk("t2_cred3", cred(3), 14);

    // One VC7 flit wraps rr_ptr back to 0.
    set_req(7, 1'b1, 1'b1, 1'b1, tag(7, 9));
    #1;
    chk("t3_pre_ready", fdi_if.vc_req_ready, 8'h80);
    step();
    set_req(7, 1'b0, 1'b0, 1'b0, '0);
    // VC2 3-flit packet locks out VC4.
    set_req(2, 1'b1, 1'b1, 1'b0, tag(2, 0));
    set_req(4, 1'b1, 1'b1, 1'b1, tag(4, 0));
    #1;
    chk("t3_r0", fdi_if.vc_req_ready, 8'h04);
    step();
    chk("t3_d0", fdi_if.pl_flit_data, tag(2, 0));
    chk("t3_sop0", {fdi_if.pl_flit_sop, fdi_if.pl_flit_eop}, 2'b10);
    set_req(2, 1'b1, 1'b0, 1'b0, tag(2, 1));
    #1;
    chk("t3_r1_locked", fdi_if.vc_req_ready, 8'h04);
    step();
    chk("t3_d1", fdi_if.pl_flit_data, tag(2, 1));
    set_req(2, 1'b1, 1'b0, 1'b1, tag(2, 2));
    #1;
    chk("t3_r2_locked", fdi_if.vc_req_ready, 8'h04);
    step();
    chk("t3_d2", fdi_if.pl_flit_data, tag(2, 2));
    chk("t3_eop2", {fdi_if.pl_flit_sop, fdi_if.pl_flit_eop}, 2'b01);
    set_req(2, 1'b0, 1'b0, 1'b0, '0);
    #1;
    chk("t3_r3", fdi_if.vc_req_ready, 8'h10);
    step();
    chk("t3_d3", fdi_if.pl_flit_data, tag(4, 0));
    set_req(4, 1'b0, 1'b0, 1'b0, '0);
    chk("t3_cred2", cred(2), 13);

    // Backpressure holds the VC6 flit for 5 cycles.
    set_req(6, 1'b1, 1'b1, 1'b1, tag(6, 0));
    #1;
    chk("t4_accept", fdi_if.vc_req_ready, 8'h40);
    step();
    set_req(6, 1'b0, 1'b0, 1'b0, '0);
    set_req(5, 1'b1, 1'b1, 1'b1, tag(5, 0));
    fdi_if.lp_flit_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_noready", fdi_if.vc_req_ready, 0);
      chk("t4_valid", fdi_if.pl_flit_valid, 1);
      chk("t4_data", fdi_if.pl_flit_data, tag(6, 0));
      step();
    end
    chk("t4_cred5", cred(5), 14);
    chk("t4_cred6", cred(6), 15);
    set_req(5, 1'b0, 1'b0, 1'b0, '0);
    fdi_if.lp_flit_ready = 1'b1;
    step();
    chk("t4_drained", fdi_if.pl_flit_valid, 0);

    // Accept + return together on VC6, then saturate it.
    set_req(6, 1'b1, 1'b1, 1'b1, tag(6, 1));
    fdi_if.pl_credit_return[6] = 1'b1;
    #1;
    chk("t5_accept", fdi_if.vc_req_ready, 8'h40);
    step();
    set_req(6, 1'b0, 1'b0, 1'b0, '0);
    chk("t5_cred_same", cred(6), 15);
    for (int i = 0; i < 48; i++) step();
    chk("t5_cred63", cred(6), 63);
    chk("t5_no_ovf", fdi_if.credit_overflow, 0);
    step();
    fdi_if.pl_credit_return = '0;
    chk("t5_cred_sat", cred(6), 63);
    chk("t5_ovf", fdi_if.credit_overflow, 1);
    step();
    chk("t5_ovf_sticky", fdi_if.credit_overflow, 1);

    // Link drop mid-packet on VC7.
    set_req(7, 1'b1, 1'b1, 1'b0, tag(7, 0));
    #1;
    chk("t6_accept", fdi_if.vc_req_ready, 8'h80);
    step();
    fdi_if.link_up       = 1'b0;
    fdi_if.lp_flit_ready = 1'b0;
    set_req(7, 1'b1, 1'b0, 1'b0, tag(7, 1));
    set_req(1, 1'b1, 1'b1, 1'b1, tag(1, 1));
    #1;
    chk("t6_nogrant", fdi_if.vc_req_ready, 0);
    step();
    chk("t6_cred_init", fdi_if.credit_count, {NV{6'd16}});
    chk("t6_ovf_kept", fdi_if.credit_overflow, 1);
    chk("t6_held", fdi_if.pl_flit_valid, 1);
    chk("t6_held_data", fdi_if.pl_flit_data, tag(7, 0));
    fdi_if.lp_flit_ready = 1'b1;
    #1;
    chk("t6_nogrant2", fdi_if.vc_req_ready, 0);
    step();
    chk("t6_drained", fdi_if.pl_flit_valid, 0);
    fdi_if.link_up = 1'b1;
    #1;
    chk("t6_idle_rr", fdi_if.vc_req_ready, 8'h02);
    step();
    chk("t6_data", fdi_if.pl_flit_data, tag(1, 1));
    set_req(1, 1'b0, 1'b0, 1'b0, '0);
    set_req(7, 1'b0, 1'b0, 1'b0, '0);

`ifdef UCIE_FDI_TX_CANCEL_EN
    // Cancel replays the last flit the FDI took.
    set_req(3, 1'b1, 1'b1, 1'b1, a5);
    #1;
    chk("c_accept", fdi_if.vc_req_ready, 8'h08);
    step();
    set_req(3, 1'b0, 1'b0, 1'b0, '0);
    chk("c_first", fdi_if.pl_flit_data, a5);
    step();
    chk("c_sent", fdi_if.pl_flit_valid, 0);
    fdi_if.pl_flit_cancel = 1'b1;
    set_req(1, 1'b1, 1'b1, 1'b1, tag(1, 2));
    #1;
    chk("c_block", fdi_if.vc_req_ready, 0);
    chk("c_ack", fdi_if.pl_flit_cancel_ack, 1);
    step();
    fdi_if.pl_flit_cancel = 1'b0;
    set_req(1, 1'b0, 1'b0, 1'b0, '0);
    #1;
    chk("c_ack_pulse", fdi_if.pl_flit_cancel_ack, 0);
    chk("c_replay_vld", fdi_if.pl_flit_valid, 1);
    chk("c_replay_data", fdi_if.pl_flit_data, a5);
    chk("c_cred3", cred(3), 15);
    step();
`endif

    reset = 1'b1;
    #1;
    chk("end_rst_ovf", fdi_if.credit_overflow, 0);
    chk("end_rst_cred", fdi_if.credit_count, {NV{6'd16}});
    chk("end_rst_valid", fdi_if.pl_flit_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
